param_collapse_issue_queue: RTL and testbench

// Parametrised collapsing (age-ordered) issue queue for single-cycle integer FUs; successor of the fixed 32-entry simple IQ.

---
 rtl/param_collapse_issue_queue_if.sv | 60 ++++++
 rtl/param_collapse_issue_queue.sv | 176 +++++++++++++++++
 tb/tb_param_collapse_issue_queue.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_collapse_issue_queue_if.sv
// param_collapse_issue_queue_if
// Bundles everything between the collapsing issue queue and its neighbours:
//   flush                          pipeline flush request
//   disp_*                         dispatch group (up to DISP_W uops) and the accept/credit outputs
//   wb_valid/wb_tag                write-back wakeup broadcasts (WB_W ports)
//   pre_valid/pre_tag              pre-wakeup broadcasts from sibling selects (PRE_W ports)
//   iss_*                          issue handshake towards the single-cycle FU
// The master modport is the pipeline/FU side; the slave modport is the queue itself.
interface param_collapse_issue_queue_if #(
   parameter int DISP_W    = 4,
   parameter int WB_W      = 4,
   parameter int PRE_W     = 2,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 64
);
   localparam int NUM_W  = $clog2(DISP_W + 1);
   localparam int FREE_W = $clog2(DISP_W + 2);

   logic                        flush;
   logic                        disp_valid;
   logic [NUM_W-1:0]            disp_num;
   logic [DISP_W-1:0]           disp_rj_valid;
   logic [DISP_W*PREG_W-1:0]    disp_rj_tag;
   logic [DISP_W-1:0]           disp_rj_rdy;
   logic [DISP_W-1:0]           disp_rk_valid;
   logic [DISP_W*PREG_W-1:0]    disp_rk_tag;
   logic [DISP_W-1:0]           disp_rk_rdy;
   logic [DISP_W-1:0]           disp_rd_valid;
   logic [DISP_W*PREG_W-1:0]    disp_rd_tag;
   logic [DISP_W*PAYLOAD_W-1:0] disp_payload;
   logic                        disp_ready;
   logic [FREE_W-1:0]           free_cnt;
   logic [WB_W-1:0]             wb_valid;
   logic [WB_W*PREG_W-1:0]      wb_tag;
   logic [PRE_W-1:0]            pre_valid;
   logic [PRE_W*PREG_W-1:0]     pre_tag;
   logic                        iss_valid;
   logic                        iss_ready;
   logic [PREG_W-1:0]           iss_rj_tag;
   logic [PREG_W-1:0]           iss_rk_tag;
   logic [PREG_W-1:0]           iss_rd_tag;
   logic                        iss_rd_valid;
   logic [PAYLOAD_W-1:0]        iss_payload;

   modport master (
      output flush, disp_valid, disp_num, disp_rj_valid, disp_rj_tag, disp_rj_rdy,
             disp_rk_valid, disp_rk_tag, disp_rk_rdy, disp_rd_valid, disp_rd_tag, disp_payload,
             wb_valid, wb_tag, pre_valid, pre_tag, iss_ready,
      input  disp_ready, free_cnt, iss_valid, iss_rj_tag, iss_rk_tag, iss_rd_tag,
             iss_rd_valid, iss_payload
   );

   modport slave (
      input  flush, disp_valid, disp_num, disp_rj_valid, disp_rj_tag, disp_rj_rdy,
             disp_rk_valid, disp_rk_tag, disp_rk_rdy, disp_rd_valid, disp_rd_tag, disp_payload,
             wb_valid, wb_tag, pre_valid, pre_tag, iss_ready,
      output disp_ready, free_cnt, iss_valid, iss_rj_tag, iss_rk_tag, iss_rd_tag,
             iss_rd_valid, iss_payload
   );
endinterface

// File: rtl/param_collapse_issue_queue.sv
// param_collapse_issue_queue
// Age-ordered collapsing issue queue feeding one single-cycle integer FU. Entry 0 is the oldest;
// occupied entries are always [0, cnt). Up to DISP_W uops are appended per cycle (all-or-nothing),
// sources are woken by write-back and pre-wakeup tag broadcasts, and the oldest ready entry is
// presented combinationally on the issue handshake. On fire the younger entries slide down by one.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   param_collapse_issue_queue_if.slave (flush, dispatch, wakeup and issue signals)
// Optional feature macro: SIQ_SELF_WAKEUP_EN -- when defined, the destination tag of the uop that
// fires is broadcast internally as an extra wakeup source at the same edge.
module param_collapse_issue_queue #(
   parameter int DEPTH     = 32,
   parameter int DISP_W    = 4,
   parameter int WB_W      = 4,
   parameter int PRE_W     = 2,
   parameter int PREG_W    = 6,
   parameter int PAYLOAD_W = 64
) (
   input logic                       clk,
   input logic                       rst,
   param_collapse_issue_queue_if.slave bus
);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int SEL_W  = $clog2(DEPTH);
   localparam int FREE_W = $clog2(DISP_W + 2);

   typedef struct packed {
      logic                 valid;
      logic                 rj_valid;
      logic [PREG_W-1:0]    rj_tag;
      logic                 rj_rdy;
      logic                 rk_valid;
      logic [PREG_W-1:0]    rk_tag;
      logic                 rk_rdy;
      logic                 rd_valid;
      logic [PREG_W-1:0]    rd_tag;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t            q       [DEPTH];
   entry_t            q_n     [DEPTH];
   entry_t            shifted [DEPTH];
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic [CNT_W-1:0]  free_slots;
   logic [DEPTH-1:0]  rdy_vec;
   logic              any_rdy;
   logic [SEL_W-1:0]  sel;
   logic              iss_valid_int;
   logic              fire;
   logic              accept;
   logic              self_valid;
   logic [PREG_W-1:0] self_tag;

   // True when any validated broadcast port (or the internal self-wakeup) carries this tag.
   function automatic logic tag_hit(
      input logic [PREG_W-1:0]       tag,
      input logic [WB_W-1:0]         wv,
      input logic [WB_W*PREG_W-1:0]  wt,
      input logic [PRE_W-1:0]        pv,
      input logic [PRE_W*PREG_W-1:0] pt,
      input logic                    sv,
      input logic [PREG_W-1:0]       st
   );
      logic h;
      h = sv && (st == tag);
      for (int w = 0; w < WB_W; w++)
         if (wv[w] && (wt[w*PREG_W +: PREG_W] == tag)) h = 1'b1;
      for (int p = 0; p < PRE_W; p++)
         if (pv[p] && (pt[p*PREG_W +: PREG_W] == tag)) h = 1'b1;
      return h;
   endfunction

   // Oldest-first select over the registered state: the first ready entry from index 0 wins.
   always_comb begin
      rdy_vec = '0;
      any_rdy = 1'b0;
      sel     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdy_vec[i] = q[i].valid & (!q[i].rj_valid | q[i].rj_rdy) & (!q[i].rk_valid | q[i].rk_rdy);
         if (rdy_vec[i] && !any_rdy) begin
            any_rdy = 1'b1;
            sel     = SEL_W'(i);
         end
      end
   end

   // Issue side: a flush cycle never issues, and all issue fields read zero when nothing is presented.
   always_comb begin
      iss_valid_int    = any_rdy & !bus.flush;
      fire             = iss_valid_int & bus.iss_ready;
      bus.iss_valid    = iss_valid_int;
      bus.iss_rj_tag   = iss_valid_int ? q[sel].rj_tag   : '0;
      bus.iss_rk_tag   = iss_valid_int ? q[sel].rk_tag   : '0;
      bus.iss_rd_tag   = iss_valid_int ? q[sel].rd_tag   : '0;
      bus.iss_rd_valid = iss_valid_int ? q[sel].rd_valid : 1'b0;
      bus.iss_payload  = iss_valid_int ? q[sel].payload  : '0;
   end

   // Self-wakeup source: the firing uop's destination, only when the feature is built in.
   always_comb begin
`ifdef SIQ_SELF_WAKEUP_EN
      self_valid = fire & q[sel].rd_valid;
      self_tag   = q[sel].rd_tag;
`else
      self_valid = 1'b0;
      self_tag   = '0;
`endif
   end

   // Dispatch credit comes only from the registered count; a same-cycle fire does not free a slot early.
   always_comb begin
      free_slots     = CNT_W'(DEPTH) - cnt;
      bus.disp_ready = (int'(free_slots) >= int'(bus.disp_num));
      bus.free_cnt   = (int'(free_slots) > DISP_W + 1) ? FREE_W'(DISP_W + 1) : FREE_W'(free_slots);
      accept         = bus.disp_valid & bus.disp_ready & !bus.flush;
   end

   // Next-state: collapse above the fired slot, append the accepted group right after the surviving
   // entries, then apply wakeups to the resulting entries so freshly dispatched sources never miss one.
   always_comb begin
      int     base;
      int     num;
      int     k;
      entry_t e;
      base = int'(cnt) - (fire ? 1 : 0);
      num  = accept ? int'(bus.disp_num) : 0;
      k    = 0;
      e    = '0;
      for (int i = 0; i < DEPTH - 1; i++) shifted[i] = q[i + 1];
      shifted[DEPTH-1] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         e = (fire && (i >= int'(sel))) ? shifted[i] : q[i];
         if ((i >= base) && (i < base + num)) begin
            k          = i - base;
            e.valid    = 1'b1;
            e.rj_valid = bus.disp_rj_valid[k];
            e.rj_tag   = bus.disp_rj_tag[k*PREG_W +: PREG_W];
            e.rj_rdy   = bus.disp_rj_rdy[k];
            e.rk_valid = bus.disp_rk_valid[k];
            e.rk_tag   = bus.disp_rk_tag[k*PREG_W +: PREG_W];
            e.rk_rdy   = bus.disp_rk_rdy[k];
            e.rd_valid = bus.disp_rd_valid[k];
            e.rd_tag   = bus.disp_rd_tag[k*PREG_W +: PREG_W];
            e.payload  = bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
         end
         if (tag_hit(e.rj_tag, bus.wb_valid, bus.wb_tag, bus.pre_valid, bus.pre_tag, self_valid, self_tag))
            e.rj_rdy = 1'b1;
         if (tag_hit(e.rk_tag, bus.wb_valid, bus.wb_tag, bus.pre_valid, bus.pre_tag, self_valid, self_tag))
            e.rk_rdy = 1'b1;
         if (bus.flush) e.valid = 1'b0;
         q_n[i] = e;
      end
      cnt_n = bus.flush ? '0 : CNT_W'(base + num);
   end

   // State register; reset only needs to clear occupancy and readiness, the rest is don't-care.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q[i].valid  <= 1'b0;
            q[i].rj_rdy <= 1'b0;
            q[i].rk_rdy <= 1'b0;
         end
      end else begin
         cnt <= cnt_n;
         q   <= q_n;
      end
   end

   // A dispatch group larger than the dispatch width is a protocol error upstream.
   disp_num_legal: assert property (@(posedge clk) disable iff (rst)
      !(bus.disp_valid && (int'(bus.disp_num) > DISP_W)));
endmodule

// File: tb/tb_param_collapse_issue_queue.sv
// tb_param_collapse_issue_queue
// Scoreboarded bench for param_collapse_issue_queue: expected issue payloads are queued when the
// stimulus that determines them is driven and popped whenever the FU handshake fires.
module tb_param_collapse_issue_queue;
   localparam int DEPTH     = 32;
   localparam int DISP_W    = 4;
   localparam int WB_W      = 4;
   localparam int PRE_W     = 2;
   localparam int PREG_W    = 6;
   localparam int PAYLOAD_W = 64;

   logic clk = 1'b0;
   logic rst;
   int   numChecks = 0;
   int   numFails  = 0;
   logic [PAYLOAD_W-1:0] expQ [$];
   logic [PAYLOAD_W-1:0] expPayload;

   always #5 clk = ~clk;

   param_collapse_issue_queue_if #(.DISP_W(DISP_W), .WB_W(WB_W), .PRE_W(PRE_W),
      .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

   param_collapse_issue_queue #(.DEPTH(DEPTH), .DISP_W(DISP_W), .WB_W(WB_W), .PRE_W(PRE_W),
      .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard: each handshake fire must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.iss_valid === 1'b1 && bus.iss_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("sb_unexpected_issue", bus.iss_payload, '0);
         end else begin
            expPayload = expQ.pop_front();
            checkOutput("sb_issue_payload", bus.iss_payload, expPayload);
         end
      end
   end

   // Hard stop in case something stalls forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.flush         = 1'b0;
      bus.disp_valid    = 1'b0;
      bus.disp_num      = '0;
      bus.disp_rj_valid = '0;
      bus.disp_rj_tag   = '0;
      bus.disp_rj_rdy   = '0;
      bus.disp_rk_valid = '0;
      bus.disp_rk_tag   = '0;
      bus.disp_rk_rdy   = '0;
      bus.disp_rd_valid = '0;
      bus.disp_rd_tag   = '0;
      bus.disp_payload  = '0;
      bus.wb_valid      = '0;
      bus.wb_tag        = '0;
      bus.pre_valid     = '0;
      bus.pre_tag       = '0;
      bus.iss_ready     = 1'b0;
   endtask

   task automatic setSlot(input int k,
                          input logic rjv, input logic [PREG_W-1:0] rjt, input logic rjr,
                          input logic rkv, input logic [PREG_W-1:0] rkt, input logic rkr,
                          input logic rdv, input logic [PREG_W-1:0] rdt,
                          input logic [PAYLOAD_W-1:0] pl);
      bus.disp_rj_valid[k]                     = rjv;
      bus.disp_rj_tag[k*PREG_W +: PREG_W]      = rjt;
      bus.disp_rj_rdy[k]                       = rjr;
      bus.disp_rk_valid[k]                     = rkv;
      bus.disp_rk_tag[k*PREG_W +: PREG_W]      = rkt;
      bus.disp_rk_rdy[k]                       = rkr;
      bus.disp_rd_valid[k]                     = rdv;
      bus.disp_rd_tag[k*PREG_W +: PREG_W]      = rdt;
      bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl;
   endtask

   // Presents a dispatch group for one cycle and checks the accept decision before the edge.
   task automatic applyStimulus(input int n, input logic expReady, input string tag);
      bus.disp_valid = 1'b1;
      bus.disp_num   = 3'(n);
      @(negedge clk);
      checkOutput(tag, bus.disp_ready, expReady);
      step();
      bus.disp_valid = 1'b0;
      bus.disp_num   = '0;
   endtask

   // One-cycle write-back broadcast on port 0.
   task automatic broadcastWb(input logic [PREG_W-1:0] tag);
      bus.wb_valid[0]        = 1'b1;
      bus.wb_tag[PREG_W-1:0] = tag;
      step();
      bus.wb_valid = '0;
   endtask

   // Accepts issues until the scoreboard empties, with a bounded cycle budget.
   task automatic drain(input int maxCycles, input string tag);
      int n;
      n = 0;
      bus.iss_ready = 1'b1;
      while (expQ.size() != 0 && n < maxCycles) begin
         step();
         n++;
      end
      checkOutput(tag, 64'(expQ.size()), 64'd0);
      bus.iss_ready = 1'b0;
   endtask

   initial begin
      clearInputs();

      // Reset and first group of four independent uops issuing back to back.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_iss_valid", bus.iss_valid, 1'b0);
      checkOutput("rst_iss_payload", bus.iss_payload, '0);
      checkOutput("rst_free_cnt", bus.free_cnt, 3'd5);
      checkOutput("rst_disp_ready", bus.disp_ready, 1'b1);
      step();
      bus.iss_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         setSlot(k, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 6'(10 + k), 64'(100 + k));
         expQ.push_back(64'(100 + k));
      end
      applyStimulus(4, 1'b1, "t1_disp_ready");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("t1_iss_valid", bus.iss_valid, 1'b1);
         if (c == 0) checkOutput("t1_rd_tag", bus.iss_rd_tag, 6'd10);
         step();
      end
      @(negedge clk);
      checkOutput("t1_empty", bus.iss_valid, 1'b0);
      checkOutput("t1_sb_left", 64'(expQ.size()), 64'd0);
      step();
      bus.iss_ready = 1'b0;

      // Fill to full with blocked uops, then exercise reject, wakeup and the first free slot.
      for (int g = 0; g < 8; g++) begin
         for (int k = 0; k < 4; k++)
            setSlot(k, 1'b1, 6'd20, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'(200 + g * 4 + k));
         applyStimulus(4, 1'b1, "t2_fill_ready");
      end
      @(negedge clk);
      checkOutput("t2_full_free_cnt", bus.free_cnt, 3'd0);
      checkOutput("t2_full_no_issue", bus.iss_valid, 1'b0);
      step();
      setSlot(0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd299);
      applyStimulus(1, 1'b0, "t2_full_reject");
      applyStimulus(1, 1'b0, "t2_full_reject");
      bus.wb_tag[PREG_W-1:0] = 6'd20;
      step();
      @(negedge clk);
      checkOutput("t2_unvalidated_wb", bus.iss_valid, 1'b0);
      step();
      broadcastWb(6'd20);
      @(negedge clk);
      checkOutput("t2_wake_valid", bus.iss_valid, 1'b1);
      checkOutput("t2_wake_payload", bus.iss_payload, 64'd200);
      step();
      expQ.push_back(64'd200);
      bus.iss_ready = 1'b1;
      applyStimulus(1, 1'b0, "t2_no_fire_credit");
      bus.iss_ready = 1'b0;
      @(negedge clk);
      checkOutput("t2_free_after_fire", bus.free_cnt, 3'd1);
      step();
      applyStimulus(1, 1'b1, "t2_accept_after_fire");
      for (int i = 201; i < 232; i++) expQ.push_back(64'(i));
      expQ.push_back(64'd299);
      drain(40, "t2_drain");
      @(negedge clk);
      checkOutput("t2_drained", bus.iss_valid, 1'b0);
      step();

      // Younger ready uop overtakes an older blocked one, which then issues after a WB on port 2.
      setSlot(0, 1'b1, 6'd7, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd300);
      setSlot(1, 1'b0, '0, 1'b0, 1'b1, 6'd8, 1'b1, 1'b0, '0, 64'd301);
      applyStimulus(2, 1'b1, "t3_disp_ready");
      @(negedge clk);
      checkOutput("t3_first_payload", bus.iss_payload, 64'd301);
      checkOutput("t3_first_rj_tag", bus.iss_rj_tag, 6'd0);
      step();
      expQ.push_back(64'd301);
      expQ.push_back(64'd300);
      bus.iss_ready = 1'b1;
      bus.wb_valid[2] = 1'b1;
      bus.wb_tag[2*PREG_W +: PREG_W] = 6'd7;
      step();
      bus.wb_valid = '0;
      @(negedge clk);
      checkOutput("t3_second_valid", bus.iss_valid, 1'b1);
      checkOutput("t3_second_rj_tag", bus.iss_rj_tag, 6'd7);
      step();
      bus.iss_ready = 1'b0;
      @(negedge clk);
      checkOutput("t3_empty", bus.iss_valid, 1'b0);
      step();

      // Pre-wakeup arriving in the dispatch cycle must not be lost; an unrelated tag stays blocked.
      setSlot(0, 1'b1, 6'd9, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd400);
      setSlot(1, 1'b1, 6'd11, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd401);
      bus.pre_valid[0] = 1'b1;
      bus.pre_tag[PREG_W-1:0] = 6'd9;
      applyStimulus(2, 1'b1, "t4_disp_ready");
      bus.pre_valid = '0;
      @(negedge clk);
      checkOutput("t4_same_cycle_wake", bus.iss_payload, 64'd400);
      step();
      expQ.push_back(64'd400);
      bus.iss_ready = 1'b1;
      step();
      bus.iss_ready = 1'b0;
      @(negedge clk);
      checkOutput("t4_unwoken_waits", bus.iss_valid, 1'b0);
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;

      // Ten entries, only entry 3 ready; fire it while a two-uop group arrives, then check the order.
      for (int id = 0; id < 10; id++) begin
         setSlot(id % 4, (id != 3), 6'd30, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'(500 + id));
         if (id == 3) applyStimulus(4, 1'b1, "t5_build");
         if (id == 7) applyStimulus(4, 1'b1, "t5_build");
         if (id == 9) applyStimulus(2, 1'b1, "t5_build");
      end
      @(negedge clk);
      checkOutput("t5_sel_p3", bus.iss_payload, 64'd503);
      step();
      expQ.push_back(64'd503);
      bus.iss_ready = 1'b1;
      setSlot(0, 1'b1, 6'd30, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd510);
      setSlot(1, 1'b1, 6'd30, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd511);
      applyStimulus(2, 1'b1, "t5_disp_with_fire");
      bus.iss_ready = 1'b0;
      @(negedge clk);
      checkOutput("t5_all_blocked", bus.iss_valid, 1'b0);
      step();
      broadcastWb(6'd30);
      for (int id = 0; id < 10; id++) if (id != 3) expQ.push_back(64'(500 + id));
      expQ.push_back(64'd510);
      expQ.push_back(64'd511);
      drain(20, "t5_drain");
      @(negedge clk);
      checkOutput("t5_cnt_exact", bus.iss_valid, 1'b0);
      step();
      for (int k = 0; k < 3; k++)
         setSlot(k, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'(520 + k));
      applyStimulus(3, 1'b1, "t5_refill");
      setSlot(0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd529);
      bus.flush      = 1'b1;
      bus.iss_ready  = 1'b1;
      bus.disp_valid = 1'b1;
      bus.disp_num   = 3'd1;
      @(negedge clk);
      checkOutput("t5_flush_no_issue", bus.iss_valid, 1'b0);
      step();
      bus.flush      = 1'b0;
      bus.disp_valid = 1'b0;
      bus.disp_num   = '0;
      @(negedge clk);
      checkOutput("t5_flush_empty", bus.iss_valid, 1'b0);
      checkOutput("t5_flush_free_cnt", bus.free_cnt, 3'd5);
      step();
      bus.iss_ready = 1'b0;

      // Dependent uop B (rj=5) behind producer A (rd=5).
      setSlot(0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 6'd5, 64'd600);
      setSlot(1, 1'b1, 6'd5, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 64'd601);
      applyStimulus(2, 1'b1, "t6_disp_ready");
      @(negedge clk);
      checkOutput("t6_producer", bus.iss_payload, 64'd600);
      step();
      expQ.push_back(64'd600);
      bus.iss_ready = 1'b1;
      step();
`ifdef SIQ_SELF_WAKEUP_EN
      expQ.push_back(64'd601);
      @(negedge clk);
      checkOutput("t6_self_wake", bus.iss_valid, 1'b1);
      step();
`else
      @(negedge clk);
      checkOutput("t6_no_self_wake", bus.iss_valid, 1'b0);
      step();
      broadcastWb(6'd5);
      expQ.push_back(64'd601);
      @(negedge clk);
      checkOutput("t6_wb_wake", bus.iss_valid, 1'b1);
      step();
`endif
      bus.iss_ready = 1'b0;
      @(negedge clk);
      checkOutput("t6_empty", bus.iss_valid, 1'b0);
      checkOutput("final_sb_left", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end
endmodule
